// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N requesters; issue appears the cycle after grant.
// Issue port holds until i_ALU_READY; results route back in order via a tag FIFO that throttles grants when full.
module alu_rr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               i_RSTn,
  input  logic [N-1:0]       i_REQ_VALID,
  input  logic [N*WIDTH-1:0] i_REQ_A,
  input  logic [N*WIDTH-1:0] i_REQ_B,
  input  logic [N*OPW-1:0]   i_REQ_OP,
  output logic [N-1:0]       o_REQ_READY,
  output logic               o_ALU_VALID,
  output logic [WIDTH-1:0]   o_ALU_A,
  output logic [WIDTH-1:0]   o_ALU_B,
  output logic [OPW-1:0]     o_ALU_OP,
  input  logic               i_ALU_READY,
  input  logic               i_RES_VALID,
  input  logic [WIDTH-1:0]   i_RES_Y,
  output logic               o_RES_READY,
  output logic [N-1:0]       o_RSP_VALID,
  output logic [WIDTH-1:0]   o_RSP_Y,
  input  logic [N-1:0]       i_RSP_READY,
  output logic               o_ERR
);

  localparam int IW = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic [OPW-1:0]   iss_op;
  logic             err_q;

  logic [IW-1:0]    tag_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    tag_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [IW-1:0]    head;
  logic             hold_ack;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic             grant;
  logic             res_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (tag_cnt == CW'(DEPTH));
  assign fifo_empty = (tag_cnt == '0);
  assign head       = tag_mem[rd_ptr];
  assign hold_ack   = (state == ST_HOLD) && i_ALU_READY;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr) + i) % N);
      if (i_REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A pop in the same cycle does not free a slot for a grant when full.
  assign grant = !i_RSTn && win_found && !fifo_full && ((state == ST_IDLE) || hold_ack);

  always_comb begin
    o_REQ_READY = '0;
    if (grant) o_REQ_READY[win_idx] = 1'b1;
  end

  assign o_ALU_VALID = (state == ST_HOLD);
  assign o_ALU_A     = iss_a;
  assign o_ALU_B     = iss_b;
  assign o_ALU_OP    = iss_op;

  // With nothing outstanding, any returning result is swallowed and flagged.
  always_comb begin
    o_RSP_VALID = '0;
    o_RSP_Y     = '0;
    o_RES_READY = 1'b1;
    if (!fifo_empty) begin
      o_RSP_VALID[head] = i_RES_VALID;
      o_RSP_Y           = i_RES_Y;
      o_RES_READY       = i_RSP_READY[head];
    end
  end

  assign res_pop = i_RES_VALID && !fifo_empty && i_RSP_READY[head];
  assign o_ERR   = err_q;

  always_ff @(posedge clk or posedge i_RSTn) begin
    if (i_RSTn) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      iss_a  <= '0;
      iss_b  <= '0;
      iss_op <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant) begin
        state  <= ST_HOLD;
        iss_a  <= i_REQ_A[int'(win_idx) * WIDTH +: WIDTH];
        iss_b  <= i_REQ_B[int'(win_idx) * WIDTH +: WIDTH];
        iss_op <= i_REQ_OP[int'(win_idx) * OPW +: OPW];
        rr_ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end else if (hold_ack) begin
        state <= ST_IDLE;
      end
      if (i_RES_VALID && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_RSTn) begin
    if (i_RSTn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (grant)   wr_ptr <= ptr_inc(wr_ptr);
      if (res_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({grant, res_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win_idx;
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: queue-based reference model predicts grants, issues and responses;
// a separate monitor compares the issue and response ports against the expected queues.
module tb_alu_rr_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;

  typedef logic [N-1:0]       req_t;
  typedef logic [N*WIDTH-1:0] dat_t;
  typedef logic [N*OPW-1:0]   opv_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } iss_t;

  typedef struct {
    int               k;
    logic [WIDTH-1:0] y;
  } rsp_t;

  logic             clk = 1'b0;
  logic             i_RSTn;
  req_t             i_REQ_VALID;
  dat_t             i_REQ_A;
  dat_t             i_REQ_B;
  opv_t             i_REQ_OP;
  req_t             o_REQ_READY;
  logic             o_ALU_VALID;
  logic [WIDTH-1:0] o_ALU_A;
  logic [WIDTH-1:0] o_ALU_B;
  logic [OPW-1:0]   o_ALU_OP;
  logic             i_ALU_READY;
  logic             i_RES_VALID;
  logic [WIDTH-1:0] i_RES_Y;
  logic             o_RES_READY;
  req_t             o_RSP_VALID;
  logic [WIDTH-1:0] o_RSP_Y;
  req_t             i_RSP_READY;
  logic             o_ERR;

  alu_rr_arbiter #(.N(N), .WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .i_RSTn(i_RSTn),
    .i_REQ_VALID(i_REQ_VALID), .i_REQ_A(i_REQ_A), .i_REQ_B(i_REQ_B), .i_REQ_OP(i_REQ_OP),
    .o_REQ_READY(o_REQ_READY),
    .o_ALU_VALID(o_ALU_VALID), .o_ALU_A(o_ALU_A), .o_ALU_B(o_ALU_B), .o_ALU_OP(o_ALU_OP),
    .i_ALU_READY(i_ALU_READY),
    .i_RES_VALID(i_RES_VALID), .i_RES_Y(i_RES_Y), .o_RES_READY(o_RES_READY),
    .o_RSP_VALID(o_RSP_VALID), .o_RSP_Y(o_RSP_Y), .i_RSP_READY(i_RSP_READY),
    .o_ERR(o_ERR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_ptr;
  bit               m_busy;
  bit               m_err;
  int               m_tags[$];
  logic [WIDTH-1:0] alu_q[$];
  iss_t             exp_iss[$];
  rsp_t             exp_rsp[$];
  int               grant_log[$];
  int               res_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [OPW-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return b;
      default: return a;
    endcase
  endfunction

  // One clock: predict and check at the falling edge, advance the model after the rising edge.
  task automatic step();
    int               win;
    bit               ready_s, alu_hs, pop_t, res_take, spurious;
    logic [WIDTH-1:0] a, b, ra, rb;
    logic [OPW-1:0]   op, rop;
    req_t             exp_rdy;
    iss_t             it;
    rsp_t             rt;
    @(negedge clk);
    win = -1;
    a = '0; b = '0; op = '0;
    if (m_tags.size() < DEPTH && (!m_busy || i_ALU_READY))
      for (int i = 0; i < N; i++)
        if (win < 0 && i_REQ_VALID[(m_ptr + i) % N]) win = (m_ptr + i) % N;
    exp_rdy = '0;
    if (win >= 0) begin
      exp_rdy[win] = 1'b1;
      a  = i_REQ_A[win*WIDTH +: WIDTH];
      b  = i_REQ_B[win*WIDTH +: WIDTH];
      op = i_REQ_OP[win*OPW +: OPW];
    end
    check("req_ready", 32'(o_REQ_READY), 32'(exp_rdy));
    ready_s  = i_ALU_READY;
    alu_hs   = m_busy && i_ALU_READY;
    ra = o_ALU_A; rb = o_ALU_B; rop = o_ALU_OP;
    pop_t    = (m_tags.size() > 0) && i_RES_VALID && i_RSP_READY[m_tags[0]];
    spurious = (m_tags.size() == 0) && i_RES_VALID;
    res_take = pop_t || spurious;
    @(posedge clk);
    #1;
    if (res_take && alu_q.size() > 0) void'(alu_q.pop_front());
    if (alu_hs) alu_q.push_back(alu_fn(ra, rb, rop));
    if (pop_t) void'(m_tags.pop_front());
    if (spurious) m_err = 1'b1;
    if (win >= 0) begin
      it.a = a; it.b = b; it.op = op;
      exp_iss.push_back(it);
      rt.k = win; rt.y = alu_fn(a, b, op);
      exp_rsp.push_back(rt);
      m_tags.push_back(win);
      grant_log.push_back(win);
      m_ptr  = (win + 1) % N;
      m_busy = 1'b1;
    end else if (m_busy && ready_s) begin
      m_busy = 1'b0;
    end
    if (alu_q.size() > 0 && (res_mode == 2 || (res_mode == 1 && $urandom_range(0, 1) == 1))) begin
      i_RES_VALID = 1'b1;
      i_RES_Y     = alu_q[0];
    end else begin
      i_RES_VALID = 1'b0;
      i_RES_Y     = WIDTH'($urandom);
    end
  endtask

  // Monitor: compares the issue and response ports with the expected queues.
  int   mon_k;
  req_t mon_exp;
  always @(negedge clk) begin
    #1;
    if (!i_RSTn) begin
      check("alu_valid", 32'(o_ALU_VALID), 32'(exp_iss.size() > 0));
      if (exp_iss.size() > 0 && o_ALU_VALID) begin
        check("alu_a", 32'(o_ALU_A), 32'(exp_iss[0].a));
        check("alu_b", 32'(o_ALU_B), 32'(exp_iss[0].b));
        check("alu_op", 32'(o_ALU_OP), 32'(exp_iss[0].op));
        if (i_ALU_READY) void'(exp_iss.pop_front());
      end
      if (exp_rsp.size() > 0) begin
        mon_k   = exp_rsp[0].k;
        mon_exp = '0;
        if (i_RES_VALID) mon_exp[mon_k] = 1'b1;
        check("rsp_valid", 32'(o_RSP_VALID), 32'(mon_exp));
        check("res_ready", 32'(o_RES_READY), 32'(i_RSP_READY[mon_k]));
        if (i_RES_VALID && i_RSP_READY[mon_k]) begin
          check("rsp_y", 32'(o_RSP_Y), 32'(exp_rsp[0].y));
          void'(exp_rsp.pop_front());
        end
      end else begin
        check("rsp_valid_empty", 32'(o_RSP_VALID), 32'(0));
        check("res_ready_empty", 32'(o_RES_READY), 32'(1));
      end
      check("err", 32'(o_ERR), 32'(m_err));
    end
  end

  task automatic do_reset();
    i_RSTn      = 1'b1;
    i_REQ_VALID = '0;
    i_REQ_A     = '0;
    i_REQ_B     = '0;
    i_REQ_OP    = '0;
    i_ALU_READY = 1'b0;
    i_RES_VALID = 1'b0;
    i_RES_Y     = '0;
    i_RSP_READY = '0;
    m_ptr = 0; m_busy = 1'b0; m_err = 1'b0;
    m_tags.delete(); alu_q.delete(); exp_iss.delete(); exp_rsp.delete();
    repeat (2) @(posedge clk);
    #3 i_RSTn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_REQ_VALID = '0;
    i_ALU_READY = 1'b1;
    i_RSP_READY = '1;
    res_mode    = 2;
    for (int t = 0; t < 40 && (m_tags.size() > 0 || m_busy); t++) step();
    check("drain_timeout", 32'(m_tags.size()), 32'(0));
  endtask

  initial begin
    // Reset with live-looking inputs: outputs must still be quiet.
    i_RSTn = 1'b1; i_REQ_VALID = '1; i_REQ_A = 32'h11223344; i_REQ_B = 32'h55667788;
    i_REQ_OP = '1; i_ALU_READY = 1'b1; i_RES_VALID = 1'b1; i_RES_Y = 8'hAA; i_RSP_READY = '1;
    res_mode = 0; m_ptr = 0; m_busy = 1'b0; m_err = 1'b0;
    #12;
    check("rst_req_ready", 32'(o_REQ_READY), 32'(0));
    check("rst_alu_valid", 32'(o_ALU_VALID), 32'(0));
    check("rst_alu_a", 32'(o_ALU_A), 32'(0));
    check("rst_rsp_valid", 32'(o_RSP_VALID), 32'(0));
    check("rst_rsp_y", 32'(o_RSP_Y), 32'(0));
    check("rst_res_ready", 32'(o_RES_READY), 32'(1));
    check("rst_err", 32'(o_ERR), 32'(0));
    do_reset();

    // Single requester 2: 12 + 34 = 46
    i_REQ_VALID = 4'b0100; i_REQ_A = 32'h0012_0000; i_REQ_B = 32'h0034_0000; i_REQ_OP = '0;
    i_ALU_READY = 1'b1; i_RSP_READY = '1; res_mode = 0;
    step();
    i_REQ_VALID = '0;
    #1;
    check("single_alu_valid", 32'(o_ALU_VALID), 32'(1));
    check("single_alu_a", 32'(o_ALU_A), 32'h12);
    check("single_alu_b", 32'(o_ALU_B), 32'h34);
    res_mode = 2;
    step();
    #1;
    check("single_rsp_valid", 32'(o_RSP_VALID), 32'b0100);
    check("single_rsp_y", 32'(o_RSP_Y), 32'h46);
    step();
    drain();

    // Fairness from rr_ptr = 0
    do_reset();
    grant_log.delete();
    i_REQ_VALID = '1; i_ALU_READY = 1'b1; i_RSP_READY = '1; res_mode = 2;
    repeat (12) begin
      i_REQ_A = dat_t'($urandom); i_REQ_B = dat_t'($urandom); i_REQ_OP = opv_t'($urandom);
      step();
    end
    check("fair_count", 32'(grant_log.size()), 32'(12));
    for (int i = 0; i < 12; i++) check("fair_order", 32'(grant_log[i]), 32'(i % N));
    drain();

    // FIFO full: no results returned
    grant_log.delete();
    i_REQ_VALID = '1; i_ALU_READY = 1'b1; res_mode = 0;
    repeat (8) step();
    check("full_grants", 32'(grant_log.size()), 32'(DEPTH));
    check("full_ready_low", 32'(o_REQ_READY), 32'(0));
    res_mode = 2;
    step();
    res_mode = 0;
    step();
    check("full_no_grant_on_pop", 32'(grant_log.size()), 32'(DEPTH));
    step();
    check("full_one_more", 32'(grant_log.size()), 32'(DEPTH + 1));
    repeat (3) step();
    check("full_again", 32'(grant_log.size()), 32'(DEPTH + 1));
    drain();

    // Backpressure on the issue port
    grant_log.delete();
    i_REQ_VALID = 4'b0010; i_REQ_A = 32'h0000_5A00; i_REQ_B = 32'h0000_C300; i_REQ_OP = 12'h018;
    i_ALU_READY = 1'b0; res_mode = 2;
    step();
    i_REQ_A = '1; i_REQ_B = '0; i_REQ_OP = '1;
    repeat (5) begin
      step();
      check("bp_valid", 32'(o_ALU_VALID), 32'(1));
      check("bp_a", 32'(o_ALU_A), 32'h5A);
      check("bp_b", 32'(o_ALU_B), 32'hC3);
      check("bp_op", 32'(o_ALU_OP), 32'(3));
      check("bp_no_grant", 32'(grant_log.size()), 32'(1));
    end
    i_ALU_READY = 1'b1;
    step();
    check("bp_accept_grant", 32'(grant_log.size()), 32'(2));
    drain();

    // Tags 2 then 0 outstanding, only requester 0 ready
    do_reset();
    i_RSP_READY = 4'b0001; i_ALU_READY = 1'b1; res_mode = 0;
    i_REQ_VALID = 4'b0100; step();
    i_REQ_VALID = 4'b0001; step();
    i_REQ_VALID = '0; step(); step();
    res_mode = 2;
    step();
    repeat (3) begin
      #1;
      check("ooo_res_ready", 32'(o_RES_READY), 32'(0));
      check("ooo_head2", 32'(o_RSP_VALID), 32'b0100);
      step();
    end
    i_RSP_READY = 4'b0100;
    #1;
    check("ooo_res_ready2", 32'(o_RES_READY), 32'(1));
    step();
    #1;
    check("ooo_head0", 32'(o_RSP_VALID), 32'b0001);
    check("ooo_res_ready0", 32'(o_RES_READY), 32'(0));
    drain();

    // Spurious result sets a sticky error; async reset during HOLD
    res_mode = 0;
    i_RES_VALID = 1'b1; i_RES_Y = 8'h77;
    step();
    #1;
    check("err_set", 32'(o_ERR), 32'(1));
    step(); step();
    check("err_sticky", 32'(o_ERR), 32'(1));
    i_REQ_VALID = 4'b1000; i_ALU_READY = 1'b0;
    step();
    i_REQ_VALID = '0;
    #1;
    check("pre_rst_hold", 32'(o_ALU_VALID), 32'(1));
    #1 i_RSTn = 1'b1;
    #1;
    check("async_rst_alu_valid", 32'(o_ALU_VALID), 32'(0));
    check("async_rst_err", 32'(o_ERR), 32'(0));
    check("async_rst_res_ready", 32'(o_RES_READY), 32'(1));
    do_reset();
    i_REQ_VALID = 4'b1010; i_ALU_READY = 1'b1;
    #1;
    check("post_rst_winner", 32'(o_REQ_READY), 32'b0010);
    step();
    drain();

    // Randomized traffic
    grant_log.delete();
    res_mode = 1;
    repeat (1500) begin
      i_REQ_VALID = req_t'($urandom);
      i_REQ_A     = dat_t'($urandom);
      i_REQ_B     = dat_t'($urandom);
      i_REQ_OP    = opv_t'($urandom);
      i_ALU_READY = ($urandom_range(0, 3) != 0);
      i_RSP_READY = req_t'($urandom);
      step();
    end
    drain();
    check("rand_err", 32'(o_ERR), 32'(0));
    check("rand_progress", 32'(grant_log.size() > 100), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
